// File: rtl/riscv_muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit: funct3 op encodings and FSM states.
package riscv_muldiv_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX,
        ST_DONE
    } muldiv_state_e;

endpackage

// File: rtl/riscv_muldiv_unit_sign_fix.sv
// Conditional two's-complement negate; used for operand magnitudes and final sign correction.
module muldiv_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_val,
    input  logic         i_neg,
    output logic [W-1:0] o_val
);
    assign o_val = i_neg ? (~i_val + W'(1)) : i_val;
endmodule

// File: rtl/riscv_muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply, restoring divide.
// Define RISCV_MULDIV_DIV_EN to build the divider; otherwise ops 4-7 complete as illegal.
module riscv_muldiv_unit
    import riscv_muldiv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int TAG_W = 5
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [2:0]       i_in_op,
    input  logic [XLEN-1:0]  i_in_a,
    input  logic [XLEN-1:0]  i_in_b,
    input  logic [TAG_W-1:0] i_in_tag,
    input  logic             i_flush,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [XLEN-1:0]  o_out_result,
    output logic [TAG_W-1:0] o_out_tag,
    output logic             o_out_illegal,
    output logic             o_busy
);
    localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;

    muldiv_state_e     r_state;
    muldiv_op_e        r_op;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_b;
    logic              r_neg;
    logic [CW-1:0]     r_cnt;
    logic [TAG_W-1:0]  r_tag;
    logic [XLEN-1:0]   r_result;
    logic              r_valid;
    logic              r_illegal;
    logic              r_busy;

    muldiv_op_e        w_op;
    logic              w_a_neg;
    logic              w_b_neg;
    logic              w_res_neg;
    logic [XLEN-1:0]   w_abs_a;
    logic [XLEN-1:0]   w_abs_b;

    assign w_op      = muldiv_op_e'(i_in_op);
    assign w_a_neg   = i_in_a[XLEN-1] & (w_op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
    assign w_b_neg   = i_in_b[XLEN-1] & (w_op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM});
    // Remainder takes the dividend's sign; everything else the product/quotient sign.
    assign w_res_neg = (w_op == OP_REM) ? w_a_neg : (w_a_neg ^ w_b_neg);

    muldiv_sign_fix #(.W(XLEN)) u_abs_a (.i_val(i_in_a), .i_neg(w_a_neg), .o_val(w_abs_a));
    muldiv_sign_fix #(.W(XLEN)) u_abs_b (.i_val(i_in_b), .i_neg(w_b_neg), .o_val(w_abs_b));

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
    logic [XLEN-1:0]   w_addend;
    logic [XLEN:0]     w_sum;
    logic [2*XLEN-1:0] w_mul_next;
    assign w_addend   = r_acc[0] ? r_b : '0;
    assign w_sum      = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, w_addend};
    assign w_mul_next = {w_sum, r_acc[XLEN-1:1]};

    logic [2*XLEN-1:0] w_fix_in;
    logic [2*XLEN-1:0] w_fix_out;
    logic [XLEN-1:0]   w_fix_res;

`ifdef RISCV_MULDIV_DIV_EN
    // Divide: acc = {remainder, dividend/quotient}; borrow out of the trial subtract rejects it.
    logic [XLEN:0]     w_part;
    logic [XLEN:0]     w_diff;
    logic [2*XLEN-1:0] w_div_next;
    logic              w_div_zero;
    logic              w_ovf;
    logic [XLEN-1:0]   w_fast_res;

    assign w_part     = r_acc[2*XLEN-1:XLEN-1];
    assign w_diff     = w_part - {1'b0, r_b};
    assign w_div_next = !w_diff[XLEN] ? {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1}
                                      : {r_acc[2*XLEN-2:0], 1'b0};
    assign w_div_zero = (i_in_b == '0);
    assign w_ovf      = (w_op == OP_DIV || w_op == OP_REM) &&
                        (i_in_a == {1'b1, {(XLEN-1){1'b0}}}) && (&i_in_b);
    assign w_fast_res = w_div_zero ? (i_in_op[1] ? i_in_a : '1) : (i_in_op[1] ? '0 : i_in_a);
    assign w_fix_in   = !r_op[2] ? r_acc :
                        r_op[1]  ? {{XLEN{1'b0}}, r_acc[2*XLEN-1:XLEN]} :
                                   {{XLEN{1'b0}}, r_acc[XLEN-1:0]};
`else
    assign w_fix_in   = r_acc;
`endif

    muldiv_sign_fix #(.W(2*XLEN)) u_fix (.i_val(w_fix_in), .i_neg(r_neg), .o_val(w_fix_out));
    assign w_fix_res = (r_op == OP_MUL || r_op[2]) ? w_fix_out[XLEN-1:0] : w_fix_out[2*XLEN-1:XLEN];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_op      <= OP_MUL;
            r_acc     <= '0;
            r_b       <= '0;
            r_neg     <= 1'b0;
            r_cnt     <= '0;
            r_tag     <= '0;
            r_result  <= '0;
            r_valid   <= 1'b0;
            r_illegal <= 1'b0;
            r_busy    <= 1'b0;
        end else if (i_flush) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (i_in_valid) begin
                    r_op      <= w_op;
                    r_tag     <= i_in_tag;
                    r_acc     <= {{XLEN{1'b0}}, w_abs_a};
                    r_b       <= w_abs_b;
                    r_neg     <= w_res_neg;
                    r_cnt     <= CW'(XLEN-1);
                    r_illegal <= 1'b0;
                    r_busy    <= 1'b1;
                    r_state   <= ST_CALC;
`ifdef RISCV_MULDIV_DIV_EN
                    if (i_in_op[2] && (w_div_zero || w_ovf)) begin
                        r_result <= w_fast_res;
                        r_valid  <= 1'b1;
                        r_state  <= ST_DONE;
                    end
`else
                    if (i_in_op[2]) begin
                        r_result  <= '0;
                        r_illegal <= 1'b1;
                        r_valid   <= 1'b1;
                        r_state   <= ST_DONE;
                    end
`endif
                end
                ST_CALC: begin
`ifdef RISCV_MULDIV_DIV_EN
                    r_acc <= r_op[2] ? w_div_next : w_mul_next;
`else
                    r_acc <= w_mul_next;
`endif
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == '0)
                        r_state <= ST_FIX;
                end
                ST_FIX: begin
                    r_result <= w_fix_res;
                    r_valid  <= 1'b1;
                    r_state  <= ST_DONE;
                end
                ST_DONE: if (i_out_ready) begin
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_in_ready    = (r_state == ST_IDLE);
    assign o_out_valid   = r_valid;
    assign o_out_result  = r_result;
    assign o_out_tag     = r_tag;
    assign o_out_illegal = r_illegal;
    assign o_busy        = r_busy;

endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// Scoreboarded random + directed bench for riscv_muldiv_unit (XLEN=32); honours RISCV_MULDIV_DIV_EN.
module tb_riscv_muldiv_unit;
    localparam int XLEN  = 32;
    localparam int TAG_W = 5;

    logic             i_clk = 1'b0;
    logic             i_rst_n = 1'b0;
    logic             i_in_valid = 1'b0;
    logic             o_in_ready;
    logic [2:0]       i_in_op = '0;
    logic [XLEN-1:0]  i_in_a = '0;
    logic [XLEN-1:0]  i_in_b = '0;
    logic [TAG_W-1:0] i_in_tag = '0;
    logic             i_flush = 1'b0;
    logic             o_out_valid;
    logic             i_out_ready = 1'b0;
    logic [XLEN-1:0]  o_out_result;
    logic [TAG_W-1:0] o_out_tag;
    logic             o_out_illegal;
    logic             o_busy;

    riscv_muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
        .i_in_op(i_in_op), .i_in_a(i_in_a), .i_in_b(i_in_b), .i_in_tag(i_in_tag),
        .i_flush(i_flush), .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
        .o_out_result(o_out_result), .o_out_tag(o_out_tag), .o_out_illegal(o_out_illegal),
        .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        logic        ill;
        int          acc;
        int          lat;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          n_issued = 0;
    int          n_done = 0;
    bit          hold_low = 1'b0;
    bit          mon_prev = 1'b0;
    logic [31:0] held_res;
    logic [4:0]  held_tag;
    logic [4:0]  tag_n = 5'd1;

    always @(posedge i_clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic void fail(input string nm);
        total++;
        bad++;
        $display("FAIL %s: bound expired (cycle %0d)", nm, cyc);
    endfunction

    // Reference: RISC-V M semantics from plain 64-bit arithmetic.
    function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        p  = '0;
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
`ifdef RISCV_MULDIV_DIV_EN
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
`else
            default: return 32'h0;
`endif
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef RISCV_MULDIV_DIV_EN
        if (op[2] && (b == 0 || ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 1;
`else
        if (op[2]) return 1;
`endif
        return XLEN + 2;
    endfunction

    function automatic logic ref_ill(input logic [2:0] op);
`ifdef RISCV_MULDIV_DIV_EN
        return 1'b0;
`else
        return op[2];
`endif
    endfunction

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   w;
        w = 0;
        while (!o_in_ready && w < 300) begin @(posedge i_clk); #1; w++; end
        if (!o_in_ready) begin fail("accept_timeout"); return; end
        i_in_valid = 1'b1;
        i_in_op    = op;
        i_in_a     = a;
        i_in_b     = b;
        i_in_tag   = tag_n;
        @(posedge i_clk); #1;
        i_in_valid = 1'b0;
        e.res = ref_res(op, a, b);
        e.tag = tag_n;
        e.ill = ref_ill(op);
        e.acc = cyc;
        e.lat = ref_lat(op, a, b);
        sb_q.push_back(e);
        n_issued++;
        tag_n++;
        chk("busy_after_accept", o_busy, 1);
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while ((sb_q.size() != 0 || o_out_valid || !o_in_ready) && w < 400) begin
            @(posedge i_clk); #1; w++;
        end
        if (w >= 400) fail("drain_timeout");
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        forever begin
            @(posedge i_clk); #1;
            i_out_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    always @(negedge i_clk) begin
        if (i_rst_n && o_out_valid) begin
            if (!mon_prev) begin
                if (sb_q.size() == 0) fail("unexpected_result");
                else begin
                    mon_e = sb_q.pop_front();
                    chk("result", o_out_result, mon_e.res);
                    chk("tag", o_out_tag, mon_e.tag);
                    chk("illegal", o_out_illegal, mon_e.ill);
                    chk("latency", cyc - mon_e.acc + 1, mon_e.lat);
                end
                held_res = o_out_result;
                held_tag = o_out_tag;
            end else begin
                chk("hold_result", o_out_result, held_res);
                chk("hold_tag", o_out_tag, held_tag);
            end
            chk("in_ready_in_done", o_in_ready, 0);
            chk("busy_in_done", o_busy, 1);
            if (i_out_ready) n_done++;
        end
        mon_prev = i_rst_n && o_out_valid;
    end

    initial begin
        int w;
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_in_ready", o_in_ready, 1);
        chk("rst_busy", o_busy, 0);
        chk("rst_out_valid", o_out_valid, 0);
        chk("rst_result", o_out_result, 0);
        chk("rst_tag", o_out_tag, 0);
        chk("rst_illegal", o_out_illegal, 0);
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        issue(3'd0, 32'd7, 32'hFFFF_FFFD);
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(3'd4, 32'hFFFF_FFF9, 32'd2);
        issue(3'd6, 32'hFFFF_FFF9, 32'd2);
        issue(3'd5, 32'd7, 32'd0);
        issue(3'd7, 32'd7, 32'd0);
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle();

        // Consumer stalls five cycles in DONE.
        hold_low = 1'b1;
        issue(3'd0, 32'h1234_5678, 32'h9ABC_DEF0);
        w = 0;
        while (!o_out_valid && w < 100) begin @(posedge i_clk); #1; w++; end
        if (!o_out_valid) fail("hold_valid_timeout");
        repeat (5) @(posedge i_clk);
        #1;
        chk("hold_still_valid", o_out_valid, 1);
        hold_low = 1'b0;
        wait_idle();

        // Flush during CALC, then a fresh op the next cycle.
        issue(3'd1, 32'hDEAD_BEEF, 32'h0BAD_F00D);
        repeat (9) @(posedge i_clk);
        #1;
        i_flush = 1'b1;
        @(posedge i_clk); #1;
        i_flush = 1'b0;
        void'(sb_q.pop_back());
        n_issued--;
        chk("flush_valid", o_out_valid, 0);
        chk("flush_busy", o_busy, 0);
        chk("flush_in_ready", o_in_ready, 1);
        issue(3'd5, 32'd100, 32'd7);
        wait_idle();

        // Asynchronous reset mid-CALC.
        issue(3'd0, 32'h0000_0FFF, 32'h0000_0FFF);
        repeat (5) @(posedge i_clk);
        #1;
        i_rst_n = 1'b0;
        #1;
        chk("areset_busy", o_busy, 0);
        chk("areset_valid", o_out_valid, 0);
        chk("areset_in_ready", o_in_ready, 1);
        void'(sb_q.pop_back());
        n_issued--;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        for (int i = 0; i < 60; i++) begin
            issue(3'($urandom_range(0, 7)), pick(), pick());
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(posedge i_clk);
            #0;
        end
        wait_idle();
        repeat (3) @(posedge i_clk);
        #1;
        chk("completions", n_done, n_issued);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
